// File: rtl/mux_4to1_scan_ctrl_pkg.sv
// Shared types and constants for the 4-to-1 mux scan controller.
// Optional error counter is enabled by defining MUX_SCAN_ERRCNT_EN.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int          N_IN     = 4;
  localparam int          SEL_W    = 2;
  localparam logic [1:0]  SEL_LAST = 2'd3;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

endpackage

// File: rtl/mux_4to1_scan_ctrl_if.sv
// Bus between the scan controller and its environment (request side and mux side).
// err_cnt is present only when MUX_SCAN_ERRCNT_EN is defined.
interface mux_4to1_scan_ctrl_if;
  import mux_scan_pkg::*;

  logic                start;
  logic [N_IN-1:0]     d_in;
  logic [N_IN-1:0]     D;
  logic [SEL_W-1:0]    Sel;
  logic                Y;
  logic                busy;
  logic [N_IN-1:0]     q;
  logic                done;
  logic                mismatch;
`ifdef MUX_SCAN_ERRCNT_EN
  logic [7:0]          err_cnt;

  modport master (input start, d_in, Y,
                  output D, Sel, busy, q, done, mismatch, err_cnt);
  modport slave  (output start, d_in, Y,
                  input D, Sel, busy, q, done, mismatch, err_cnt);
`else
  modport master (input start, d_in, Y,
                  output D, Sel, busy, q, done, mismatch);
  modport slave  (output start, d_in, Y,
                  input D, Sel, busy, q, done, mismatch);
`endif

endinterface

// File: rtl/mux_4to1_scan_ctrl_dwell_cnt.sv
// Dwell counter: counts 0..DWELL-1 while enabled, then holds; tc flags the last dwell cycle.
module mux_scan_dwell_cnt #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = $clog2(DWELL + 1);

  generate
    if (DWELL < 1 || DWELL > 255) begin : g_bad_dwell
      $error("mux_scan_dwell_cnt: DWELL must be in 1..255");
    end
  endgenerate

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc = (cnt_q == CNT_W'(DWELL - 1));

  // Next count: clear wins, otherwise advance until terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !tc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mux_4to1_scan_ctrl.sv
// Drives a word onto the mux, steps Sel 0..3 with DWELL cycles each, captures Y and flags mismatch.
// Define MUX_SCAN_ERRCNT_EN to add the saturating err_cnt output.
module mux_4to1_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mux_4to1_scan_ctrl_if.master  bus
);

  state_e            state_q, state_d;
  logic [N_IN-1:0]   d_q, d_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [N_IN-1:0]   q_q, q_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              mismatch_q, mismatch_d;
  logic              cnt_clr, cnt_en, cnt_tc;
`ifdef MUX_SCAN_ERRCNT_EN
  logic [7:0]        err_cnt_q, err_cnt_d;
`endif

  mux_scan_dwell_cnt #(.DWELL(DWELL)) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc    (cnt_tc)
  );

  // Next-state and output decode; every register holds unless a state acts on it.
  always_comb begin
    state_d    = state_q;
    d_d        = d_q;
    sel_d      = sel_q;
    q_d        = q_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    mismatch_d = mismatch_q;
    cnt_clr    = 1'b0;
    cnt_en     = (state_q == SCAN);
`ifdef MUX_SCAN_ERRCNT_EN
    err_cnt_d  = err_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          d_d        = bus.d_in;
          sel_d      = '0;
          q_d        = '0;
          mismatch_d = 1'b0;
          busy_d     = 1'b1;
          cnt_clr    = 1'b1;
          state_d    = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (cnt_tc) begin
          q_d[sel_q] = bus.Y;
          if (sel_q == SEL_LAST) begin
            // Compare using the bit captured this edge, not the stale q_q[3].
            done_d     = 1'b1;
            mismatch_d = ({bus.Y, q_q[2:0]} != d_q);
            state_d    = DONE;
`ifdef MUX_SCAN_ERRCNT_EN
            if ({bus.Y, q_q[2:0]} != d_q) begin
              err_cnt_d = sat_inc8(err_cnt_q);
            end else begin
              err_cnt_d = err_cnt_q;
            end
`endif
          end else begin
            sel_d   = sel_q + 2'd1;
            cnt_clr = 1'b1;
          end
        end else begin
          state_d = SCAN;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      d_q        <= '0;
      sel_q      <= '0;
      q_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mismatch_q <= 1'b0;
`ifdef MUX_SCAN_ERRCNT_EN
      err_cnt_q  <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      d_q        <= d_d;
      sel_q      <= sel_d;
      q_q        <= q_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mismatch_q <= mismatch_d;
`ifdef MUX_SCAN_ERRCNT_EN
      err_cnt_q  <= err_cnt_d;
`endif
    end
  end

  assign bus.D        = d_q;
  assign bus.Sel      = sel_q;
  assign bus.q        = q_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.mismatch = mismatch_q;
`ifdef MUX_SCAN_ERRCNT_EN
  assign bus.err_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_mux_4to1_scan_ctrl.sv
// Self-checking bench: behavioural mux in loopback with fault injection, table + random scans.
// Exercises err_cnt saturation when MUX_SCAN_ERRCNT_EN is defined.
module tb_mux_4to1_scan_ctrl;

  localparam int DWELL = 4;
  localparam int SCAN_CYC = 4 * DWELL;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   fault_mode = 0;   // 0: clean mux, 1: Y forced 0 while Sel==2, 2: Y stuck 0
  int   checks = 0;
  int   errors = 0;

  mux_4to1_scan_ctrl_if bus ();

  mux_4to1_scan_ctrl #(.DWELL(DWELL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.Y = (fault_mode == 2) ? 1'b0 :
                 ((fault_mode == 1) && (bus.Sel == 2'd2)) ? 1'b0 : bus.D[bus.Sel];

  typedef struct {
    logic [3:0] w;
    int         mode;
    logic [3:0] exp_q;
    logic       exp_mm;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // What the mux hands back for bit i under each fault mode.
  function automatic logic [3:0] model_q(input logic [3:0] w, input int mode);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) begin
      if (mode == 2)                r[i] = 1'b0;
      else if (mode == 1 && i == 2) r[i] = 1'b0;
      else                          r[i] = w[i];
    end
    return r;
  endfunction

  // Full scan with per-cycle checks; repulse re-asserts start with another word mid-scan.
  task automatic do_scan(input logic [3:0] w, input int mode, input logic [3:0] exp_q,
                         input logic exp_mm, input bit repulse);
    int exp_sel;
    logic [3:0] mask;
    fault_mode = mode;
    bus.d_in   = w;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    for (int c = 0; c <= SCAN_CYC + 1; c++) begin
      exp_sel = (c >= SCAN_CYC) ? 3 : c / DWELL;
      mask = 4'b0000;
      for (int i = 0; i < 4; i++) if (c >= (i + 1) * DWELL) mask[i] = 1'b1;
      chk("sel",  int'(bus.Sel),  exp_sel);
      chk("done", int'(bus.done), (c == SCAN_CYC) ? 1 : 0);
      chk("busy", int'(bus.busy), (c <= SCAN_CYC) ? 1 : 0);
      chk("D",    int'(bus.D),    int'(w));
      chk("q_partial", int'(bus.q), int'(exp_q & mask));
      if (c < SCAN_CYC) chk("mm_cleared", int'(bus.mismatch), 0);
      if (repulse && (c == 3 || c == 10)) begin
        bus.start = 1'b1;
        bus.d_in  = 4'b1000;
      end else begin
        bus.start = 1'b0;
        bus.d_in  = w;
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    chk("q_final",  int'(bus.q),        int'(exp_q));
    chk("mismatch", int'(bus.mismatch), int'(exp_mm));
  endtask

  // Lightweight scan for long runs: bounded wait for done, then one cycle back to idle.
  task automatic quick_scan(input logic [3:0] w);
    bit got = 1'b0;
    bus.d_in  = w;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 0; c < SCAN_CYC + 8 && !got; c++) begin
      if (bus.done) got = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("scan_done", int'(got), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [3:0] rw;
    int         rm;
    vecs[0] = '{w: 4'b0001, mode: 0, exp_q: 4'b0001, exp_mm: 1'b0};
    vecs[1] = '{w: 4'b1110, mode: 0, exp_q: 4'b1110, exp_mm: 1'b0};
    vecs[2] = '{w: 4'b0100, mode: 1, exp_q: 4'b0000, exp_mm: 1'b1};
    vecs[3] = '{w: 4'b1011, mode: 1, exp_q: 4'b1011, exp_mm: 1'b0};
    vecs[4] = '{w: 4'b1111, mode: 2, exp_q: 4'b0000, exp_mm: 1'b1};
    vecs[5] = '{w: 4'b0000, mode: 2, exp_q: 4'b0000, exp_mm: 1'b0};

    bus.start = 1'b0;
    bus.d_in  = 4'b0000;
    #12;
    chk("rst_D",    int'(bus.D),        0);
    chk("rst_sel",  int'(bus.Sel),      0);
    chk("rst_q",    int'(bus.q),        0);
    chk("rst_busy", int'(bus.busy),     0);
    chk("rst_done", int'(bus.done),     0);
    chk("rst_mm",   int'(bus.mismatch), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 6; v++) begin
      do_scan(vecs[v].w, vecs[v].mode, vecs[v].exp_q, vecs[v].exp_mm, 1'b0);
    end

    // Mismatch must persist through idle cycles until the next start.
    do_scan(4'b0100, 1, 4'b0000, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("mm_held", int'(bus.mismatch), 1);
    chk("q_held",  int'(bus.q),        0);
    chk("D_held",  int'(bus.D),        4);

    // Start re-pulsed mid-scan with another word is ignored.
    do_scan(4'b0011, 0, 4'b0011, 1'b0, 1'b1);

    // Asynchronous reset mid-scan.
    fault_mode = 0;
    bus.d_in   = 4'b0110;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_D",    int'(bus.D),        0);
    chk("mid_rst_sel",  int'(bus.Sel),      0);
    chk("mid_rst_busy", int'(bus.busy),     0);
    chk("mid_rst_q",    int'(bus.q),        0);
    chk("mid_rst_done", int'(bus.done),     0);
    repeat (20) begin
      @(posedge clk); #1;
      chk("rst_no_done", int'(bus.done), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_scan(4'b1001, 0, 4'b1001, 1'b0, 1'b0);

    // Randomized scans against the model.
    for (int n = 0; n < 20; n++) begin
      rw = 4'($urandom_range(0, 15));
      rm = $urandom_range(0, 2);
      do_scan(rw, rm, model_q(rw, rm), model_q(rw, rm) != rw, 1'b0);
    end

`ifdef MUX_SCAN_ERRCNT_EN
    begin
      int exp_err;
      rst_n = 1'b0;
      #3;
      chk("err_rst", int'(bus.err_cnt), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      fault_mode = 2;
      exp_err = 0;
      for (int n = 0; n < 300; n++) begin
        quick_scan(4'b1111);
        exp_err = (exp_err < 255) ? exp_err + 1 : 255;
        if (n == 99 || n == 254 || n == 299) chk("err_cnt", int'(bus.err_cnt), exp_err);
      end
      fault_mode = 0;
      quick_scan(4'b1111);
      chk("err_cnt_clean", int'(bus.err_cnt), 255);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
